pipelined_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder. It splits WIDTH-bit operands into STAGES equal slices and adds one slice per pipeline stage, registering the carry between stages. Throughput is one addition per clock, with valid/ready handshakes on input and output. It is the general-width, registered successor to the team's 4-bit combinational adder, for datapaths where a full-width ripple chain misses timing.

---
 rtl/pipelined_adder.sv | 108 ++++++++++
 tb/tb_pipelined_adder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one SW-bit slice added per stage, carry registered between
// stages, valid/ready handshake with a single global advance enable.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SW = (STAGES == 0) ? 1 : WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % SW) != 0 || SW * STAGES != WIDTH)
  begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 1 and a multiple of STAGES (1..WIDTH)");
  end

  logic              adv;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d, cy_in;
  logic              ovf_q, ovf_d;
  logic              msb_c;

  // acc holds finished sum slices below the current stage and untouched A slices above it;
  // bsk holds the B slices still waiting to be added (consumed slices are zeroed).
  logic [WIDTH-1:0]  acc_q [STAGES];
  logic [WIDTH-1:0]  acc_d [STAGES];
  logic [WIDTH-1:0]  bsk_q [STAGES];
  logic [WIDTH-1:0]  bsk_d [STAGES];
  logic [WIDTH-1:0]  op_a  [STAGES];
  logic [WIDTH-1:0]  op_b  [STAGES];
  logic [SW:0]       ssum  [STAGES];

  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    vld_d = '0;
    cy_d  = '0;
    cy_in = '0;
    op_a  = '{default: '0};
    op_b  = '{default: '0};
    acc_d = '{default: '0};
    bsk_d = '{default: '0};
    ssum  = '{default: '0};

    vld_d[0] = in_valid && adv;
    cy_in[0] = cin;
    op_a[0]  = a;
    op_b[0]  = b;
    for (int k = 1; k < STAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      cy_in[k] = cy_q[k-1];
      op_a[k]  = acc_q[k-1];
      op_b[k]  = bsk_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      ssum[k] = {1'b0, op_a[k][k*SW +: SW]} + {1'b0, op_b[k][k*SW +: SW]}
              + {{SW{1'b0}}, cy_in[k]};
      cy_d[k]  = ssum[k][SW];
      acc_d[k] = op_a[k];
      acc_d[k][k*SW +: SW] = ssum[k][SW-1:0];
      bsk_d[k] = op_b[k];
      bsk_d[k][k*SW +: SW] = '0;
    end

    // Carry into the MSB recovered from the MSB's own sum bit.
    msb_c = op_a[STAGES-1][WIDTH-1] ^ op_b[STAGES-1][WIDTH-1] ^ ssum[STAGES-1][SW-1];
    ovf_d = cy_d[STAGES-1] ^ msb_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
        bsk_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= acc_d[k];
        bsk_q[k] <= bsk_d[k];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and streaming checks of pipelined_adder (8/4), plus a latency-aligned parameter sweep.
module tb_pipelined_adder;

  localparam int NSW = 512 + 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, sum;

  int n_checks = 0;
  int n_errors = 0;

  pipelined_adder #(.WIDTH(8), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Sweep instances share one stimulus and always accept output.
  logic [63:0] sw_a, sw_b;
  logic        sw_cin, sw_valid;
  logic [3:0]  sw_v, sw_r, sw_c, sw_o;
  logic [3:0]  s41_sum, s44_sum;
  logic [31:0] s328_sum;
  logic [63:0] s642_sum;

  pipelined_adder #(.WIDTH(4), .STAGES(1)) dut41 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_r[0]), .a(sw_a[3:0]),
    .b(sw_b[3:0]), .cin(sw_cin), .out_valid(sw_v[0]), .out_ready(1'b1), .sum(s41_sum),
    .cout(sw_c[0]), .ovf(sw_o[0])
  );
  pipelined_adder #(.WIDTH(4), .STAGES(4)) dut44 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_r[1]), .a(sw_a[3:0]),
    .b(sw_b[3:0]), .cin(sw_cin), .out_valid(sw_v[1]), .out_ready(1'b1), .sum(s44_sum),
    .cout(sw_c[1]), .ovf(sw_o[1])
  );
  pipelined_adder #(.WIDTH(32), .STAGES(8)) dut328 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_r[2]), .a(sw_a[31:0]),
    .b(sw_b[31:0]), .cin(sw_cin), .out_valid(sw_v[2]), .out_ready(1'b1), .sum(s328_sum),
    .cout(sw_c[2]), .ovf(sw_o[2])
  );
  pipelined_adder #(.WIDTH(64), .STAGES(2)) dut642 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_r[3]), .a(sw_a),
    .b(sw_b), .cin(sw_cin), .out_valid(sw_v[3]), .out_ready(1'b1), .sum(s642_sum),
    .cout(sw_c[3]), .ovf(sw_o[3])
  );

  logic [63:0] ha [NSW];
  logic [63:0] hb [NSW];
  logic        hc [NSW];
  logic        hv [NSW];

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, sum} for a w-bit add; sum is zero-extended to 64 bits.
  function automatic logic [65:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic c, input int w);
    logic [64:0] mask, full, low;
    logic        co, cm;
    mask = (65'd1 << w) - 65'd1;
    full = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {64'd0, c};
    low  = ({1'b0, x} & (mask >> 1)) + ({1'b0, y} & (mask >> 1)) + {64'd0, c};
    co   = full[w];
    cm   = low[w-1];
    return {co ^ cm, co, full[63:0] & mask[63:0]};
  endfunction

  function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [65:0] r;
    r = ref_add({56'd0, x}, {56'd0, y}, c, 8);
    return {r[65], r[64], r[7:0]};
  endfunction

  task automatic send_one(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic [9:0] exp);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = ta; b = tb; cin = tc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, " latency"}, 66'(lat), 66'd4);
    check_eq({tag, " result"}, {56'd0, ovf, cout, sum}, {56'd0, exp});
    @(posedge clk); #1;
    check_eq({tag, " valid drop"}, 66'(out_valid), 66'd0);
  endtask

  task automatic run_stream(input string tag, input int n, input int stall_at,
                            input int stall_len);
    logic [7:0] va [32];
    logic [7:0] vb [32];
    logic       vc [32];
    logic [9:0] expq [$];
    int idx, got, cyc, first, ir_low, extra;
    logic stalled;
    idx = 0; got = 0; cyc = 0; first = -1; ir_low = 0; extra = 0;
    for (int i = 0; i < n; i++) begin
      va[i] = 8'($urandom);
      vb[i] = 8'($urandom);
      vc[i] = 1'($urandom);
    end
    while (got < n && cyc < n + stall_len + 30) begin
      stalled   = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      out_ready = !stalled;
      in_valid  = (idx < n);
      if (idx < n) begin
        a = va[idx]; b = vb[idx]; cin = vc[idx];
      end
      #1;
      if (!in_ready) ir_low++;
      if (out_valid && first < 0) first = cyc;
      if (stalled && expq.size() > 0)
        check_eq({tag, " hold"}, {55'd0, out_valid, ovf, cout, sum}, {55'd0, 1'b1, expq[0]});
      if (out_valid && out_ready) begin
        if (expq.size() > 0) begin
          check_eq({tag, " result"}, {56'd0, ovf, cout, sum}, {56'd0, expq.pop_front()});
        end else begin
          check_eq({tag, " unexpected output"}, 66'd1, 66'd0);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref8(a, b, cin));
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    check_eq({tag, " accepted"}, 66'(idx), 66'(n));
    check_eq({tag, " delivered"}, 66'(got), 66'(n));
    check_eq({tag, " first out cycle"}, 66'(first), 66'd4);
    check_eq({tag, " in_ready low cycles"}, 66'(ir_low), 66'(stall_len));
    check_eq({tag, " extra outputs"}, 66'(extra), 66'd0);
  endtask

  task automatic sw_check(input string tag, input int w, input int s, input int t,
                          input logic gv, input logic gr, input logic [65:0] gdata);
    int   i;
    logic ev;
    i  = t - s + 1;
    ev = (i >= 0 && i < NSW) ? hv[i] : 1'b0;
    check_eq({tag, " valid/ready"}, {64'd0, gv, gr}, {64'd0, ev, 1'b1});
    if (ev) check_eq({tag, " data"}, gdata, ref_add(ha[i], hb[i], hc[i], w));
  endtask

  initial begin
    int stale;
    logic [8:0] tv;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_valid = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset state", {54'd0, out_valid, ovf, cout, sum, in_ready}, 66'h001);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    send_one("ff+01", 8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00});
    send_one("7f+01", 8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80});
    send_one("80+80", 8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00});
    send_one("0f+f0+1", 8'h0F, 8'hF0, 1'b1, {1'b0, 1'b1, 8'h00});

    run_stream("stream", 16, 1000, 0);
    run_stream("backpressure", 10, 6, 3);

    // Three additions in flight, the oldest already at the output, then async reset.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 8'h11 * 8'(i + 1); b = 8'h22; cin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("rst pre valid", {56'd0, out_valid, 1'b0, sum}, {56'd0, 1'b1, 1'b0, 8'h33});
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst clear", {54'd0, out_valid, ovf, cout, sum, in_ready}, 66'h001);
    #10 rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check_eq("rst stale outputs", 66'(stale), 66'd0);
    send_one("post-rst 12+34", 8'h12, 8'h34, 1'b0, {1'b0, 1'b0, 8'h46});

    for (int t = 0; t < NSW + 8; t++) begin
      if (t < 512) begin
        tv       = 9'(t);
        sw_a     = {60'd0, tv[3:0]};
        sw_b     = {60'd0, tv[7:4]};
        sw_cin   = tv[8];
        sw_valid = 1'b1;
      end else if (t < NSW) begin
        sw_a     = {$urandom, $urandom};
        sw_b     = {$urandom, $urandom};
        sw_cin   = 1'($urandom);
        sw_valid = ($urandom_range(7) != 0);
      end else begin
        sw_valid = 1'b0;
      end
      if (t < NSW) begin
        ha[t] = sw_a; hb[t] = sw_b; hc[t] = sw_cin; hv[t] = sw_valid;
      end
      @(posedge clk); #1;
      sw_check("w4s1", 4, 1, t, sw_v[0], sw_r[0], {sw_o[0], sw_c[0], 60'd0, s41_sum});
      sw_check("w4s4", 4, 4, t, sw_v[1], sw_r[1], {sw_o[1], sw_c[1], 60'd0, s44_sum});
      sw_check("w32s8", 32, 8, t, sw_v[2], sw_r[2], {sw_o[2], sw_c[2], 32'd0, s328_sum});
      sw_check("w64s2", 64, 2, t, sw_v[3], sw_r[3], {sw_o[3], sw_c[3], s642_sum});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
